palindrome_job_sequencer: RTL
=============================

Name: palindrome_job_sequencer

Overview:
Upstream feeder for the isPalindrome core. Accepts 32-bit numbers over a valid/ready input stream and launches each one into the core with a go_i level. Detects completion from the core's 4-bit state output, then returns the verdict on a valid/ready output stream. Also holds the core's go low until the core is idle again, so back-to-back numbers are analysed cleanly.

Parameters:
DONE_STATE_A, 4'd6, core state value meaning "finished, verdict valid"
DONE_STATE_B, 4'd9, second core state value meaning "finished, verdict valid"
IDLE_STATE, 4'd0, core initial state, reached after go is released
TIMEOUT_CYCLES, 256, watchdog limit per phase (WAIT and RELEASE); must be >= 2
CNT_W, 16, width of the palindrome counter

Ports:
clk  in  1  single clock; all state changes on posedge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream number valid
in_ready  out  1  sequencer can accept a number
in_number  in  32  number to analyse
core_go_o  out  1  drives core go_i
core_number_o  out  32  drives core number input; held stable from START until IDLE
core_state_i  in  4  core state output
core_result_i  in  1  core result output
out_valid  out  1  verdict available
out_ready  in  1  downstream accepts verdict
out_result  out  1  1 = palindrome (forced 0 on error)
out_number  out  32  number this verdict belongs to
out_error  out  1  verdict produced by WAIT timeout
palin_count  out  CNT_W  accepted verdicts with result=1 and error=0; saturating
stuck_flag  out  1  sticky; set on RELEASE timeout, cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; core_go_o=0, core_number_o=0, out_valid=0, out_result=0, out_number=0, out_error=0, palin_count=0, stuck_flag=0, watchdog=0.
- in_ready = (state==IDLE) AND reset. It is 0 while reset is asserted.
- FSM states and transitions:
  - IDLE: on in_valid&&in_ready, latch in_number into core_number_o and out_number, then go to START.
  - START: core_go_o<=1, watchdog<=0, then go to WAIT. Launch latency is 1 cycle from acceptance to go high.
  - WAIT: core_go_o held 1 and watchdog increments each cycle.
    - If core_state_i==DONE_STATE_A or DONE_STATE_B: out_result<=core_result_i, out_error<=0, core_go_o<=0, go to REPORT.
    - Else if watchdog==TIMEOUT_CYCLES-1: out_result<=0, out_error<=1, core_go_o<=0, go to REPORT.
    - If done and timeout occur in the same cycle, done wins.
  - REPORT: out_valid=1, with out_result, out_number and out_error stable while out_ready=0.
    - On out_ready: out_valid<=0. If out_result&&!out_error, palin_count increments, saturating at all-ones. watchdog<=0, go to RELEASE.
  - RELEASE: core_go_o=0.
    - If core_state_i==IDLE_STATE, go to IDLE.
    - Else if watchdog==TIMEOUT_CYCLES-1, stuck_flag<=1 and go to IDLE.
    - Else watchdog increments.
- Earliest next acceptance is the cycle after returning to IDLE. Minimum per-number occupancy is 1 (IDLE) + 1 (START) + core latency + 1 (REPORT) + ≥1 (RELEASE).
- in_valid while not in IDLE is ignored; in_number is not sampled.
- core_state_i at a done value during START or RELEASE is not a completion event.
- Reset mid-operation (any state) returns everything to reset values immediately, including core_go_o=0. A pending verdict is lost and not counted.
- core_result_i is sampled only in the WAIT completion cycle.

Decomposition:
- Shared package (number_analyzer_pkg):
  - FSM state encoding: IDLE, START, WAIT, REPORT, RELEASE, 3-bit.
  - Core state constants 0/6/9.
  - Default TIMEOUT_CYCLES.
- One sub-module, analyzer_watchdog: clear, enable, TIMEOUT parameter, expired output. It is reused by other analyzer sequencers (isEvenNumber).

Test Plan:
- Reset, then in_number=0xB4, core model reaching state 9 after 5 cycles with result=0 -> core_go_o high 1 cycle after acceptance, out_valid with out_result=0, out_number=0xB4, palin_count=0.
- Two back-to-back numbers 0x5 then 0x9, core reaching state 6 with result=1, out_ready always 1 -> two verdicts in order, palin_count=2, second go only after core_state returns to 0.
- Hold out_ready=0 for 10 cycles in REPORT -> out_valid/out_result/out_number stable, no new in_ready, count unchanged until accept.
- Core never reaches 6/9, TIMEOUT_CYCLES=16 -> out_error=1, out_result=0 exactly 16 cycles into WAIT, palin_count unchanged.
- Core stays in state 6 after go drops -> stuck_flag=1 after TIMEOUT_CYCLES in RELEASE, sequencer back to IDLE with in_ready=1.
- Assert reset during WAIT -> core_go_o=0 and out_valid=0 immediately (asynchronously), palin_count=0, in_ready=1 on the first edge after reset release.

Source files
------------

// File: rtl/palindrome_job_sequencer_pkg.sv
// Shared types and constants for the palindrome job sequencer.
// Core state codes and sequencer FSM encoding.
package palindrome_job_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_REPORT  = 3'd3,
        ST_RELEASE = 3'd4
    } seq_state_e;

    localparam logic [3:0] CORE_IDLE   = 4'd0;
    localparam logic [3:0] CORE_DONE_A = 4'd6;
    localparam logic [3:0] CORE_DONE_B = 4'd9;

    localparam int DEFAULT_TIMEOUT = 256;
    localparam int DEFAULT_CNT_W   = 16;

    function automatic logic is_done(
        input logic [3:0] s,
        input logic [3:0] a,
        input logic [3:0] b
    );
        return (s == a) || (s == b);
    endfunction

endpackage

// File: rtl/palindrome_job_sequencer_if.sv
// Number-in / verdict-out valid/ready streams of the sequencer.
// master = upstream/downstream environment, slave = sequencer.
interface palindrome_job_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_number;

    logic        out_valid;
    logic        out_ready;
    logic        out_result;
    logic [31:0] out_number;
    logic        out_error;

    modport master (
        output in_valid,
        output in_number,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_number,
        input  out_error
    );

    modport slave (
        input  in_valid,
        input  in_number,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_number,
        output out_error
    );

endinterface

// File: rtl/palindrome_job_sequencer_analyzer_watchdog.sv
// Per-phase cycle watchdog shared by the analyzer sequencers.
// expired_o is high while the count sits at TIMEOUT-1.
module analyzer_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/palindrome_job_sequencer.sv
// Feeds numbers into the isPalindrome core and returns its verdicts,
// holding go low until the core is idle before the next launch.
module palindrome_job_sequencer
    import palindrome_job_sequencer_pkg::*;
#(
    parameter logic [3:0] DONE_STATE_A   = CORE_DONE_A,
    parameter logic [3:0] DONE_STATE_B   = CORE_DONE_B,
    parameter logic [3:0] IDLE_STATE     = CORE_IDLE,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int         CNT_W          = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    palindrome_job_sequencer_if.slave io,
    output logic                 core_go_o,
    output logic [31:0]          core_number_o,
    input  logic [3:0]           core_state_i,
    input  logic                 core_result_i,
    output logic [CNT_W-1:0]     palin_count,
    output logic                 stuck_flag
);

    seq_state_e state_q;
    seq_state_e state_d;

    logic             go_q,     go_d;
    logic [31:0]      num_q,    num_d;
    logic             vld_q,    vld_d;
    logic             res_q,    res_d;
    logic [31:0]      onum_q,   onum_d;
    logic             err_q,    err_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stuck_q,  stuck_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    logic accept;
    logic core_done;
    logic core_idle;

    assign io.in_ready = (state_q == ST_IDLE) && reset;
    assign accept      = io.in_valid && io.in_ready;
    assign core_done   = is_done(core_state_i, DONE_STATE_A, DONE_STATE_B);
    assign core_idle   = (core_state_i == IDLE_STATE);

    analyzer_watchdog #(
        .TIMEOUT (TIMEOUT_CYCLES)
    ) u_wd (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done || wd_expired) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (io.out_ready) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (core_idle || wd_expired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        go_d      = go_q;
        num_d     = num_q;
        vld_d     = vld_q;
        res_d     = res_q;
        onum_d    = onum_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        stuck_d   = stuck_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    num_d  = io.in_number;
                    onum_d = io.in_number;
                end
            end
            ST_START: begin
                go_d     = 1'b1;
                wd_clear = 1'b1;
            end
            ST_WAIT: begin
                wd_enable = 1'b1;
                // A completion seen on the timeout cycle still wins.
                if (core_done) begin
                    res_d = core_result_i;
                    err_d = 1'b0;
                    go_d  = 1'b0;
                    vld_d = 1'b1;
                end else if (wd_expired) begin
                    res_d = 1'b0;
                    err_d = 1'b1;
                    go_d  = 1'b0;
                    vld_d = 1'b1;
                end
            end
            ST_REPORT: begin
                if (io.out_ready) begin
                    vld_d    = 1'b0;
                    wd_clear = 1'b1;
                    if (res_q && !err_q && !(&cnt_q)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                go_d = 1'b0;
                if (!core_idle) begin
                    if (wd_expired) begin
                        stuck_d = 1'b1;
                    end else begin
                        wd_enable = 1'b1;
                    end
                end
            end
            default: begin
                go_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_q    <= 1'b0;
            num_q   <= '0;
            vld_q   <= 1'b0;
            res_q   <= 1'b0;
            onum_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            stuck_q <= 1'b0;
        end else begin
            go_q    <= go_d;
            num_q   <= num_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            onum_q  <= onum_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            stuck_q <= stuck_d;
        end
    end

    assign core_go_o     = go_q;
    assign core_number_o = num_q;
    assign io.out_valid  = vld_q;
    assign io.out_result = res_q;
    assign io.out_number = onum_q;
    assign io.out_error  = err_q;
    assign palin_count   = cnt_q;
    assign stuck_flag    = stuck_q;

endmodule
